// File: rtl/alu_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_if_pkg
//  Description : Shared state encoding and ALU opcode constants for the
//                serial front end of the ALU, the ALU itself and benches.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_if_pkg;

    // Frame sequencer states: three capture states, a latency wait, a send.
    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

    // ALU opcodes (MIPS-style function codes).
    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] NOR = 6'b100111;

endpackage
`default_nettype wire

// File: rtl/alu_if_counter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_if_counter
//  Description : Clearable up-counter with a terminal-count flag. Clear has
//                priority over enable; the flag is combinational on the count.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_if_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [WIDTH-1:0] r_count;

    // Count up while enabled; synchronous clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_tc = (r_count == WIDTH'(TERMINAL));

endmodule
`default_nettype wire

// File: rtl/alu_frame_interface.sv
`default_nettype none
// ============================================================================
//  Module      : alu_frame_interface
//  Description : Collects operand A, operand B and opcode bytes from a serial
//                receiver, drives them to the ALU, waits ALU_LAT cycles for
//                the registered result and hands one result byte to the
//                transmitter via a start/busy handshake.
//                Optional macro ALU_IF_TIMEOUT_EN adds an inter-byte timeout
//                in GET_B / GET_OP that returns the sequencer to GET_A.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_frame_interface
    import alu_if_pkg::*;
#(
    parameter int N_BITS         = 6,
    parameter int N_OPS          = 6,
    parameter int N_BYTE         = 8,
    parameter int ALU_LAT        = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_BYTE-1:0] rx_data,
    input  logic              rx_valid,
    output logic [N_BITS-1:0] Data_A,
    output logic [N_BITS-1:0] Data_B,
    output logic [N_OPS-1:0]  Op,
    input  logic [N_BITS-1:0] alu_result,
    output logic [N_BYTE-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              rx_dropped
);

    localparam int c_LAT_W = $clog2(ALU_LAT + 1);

    state_t            r_state;
    logic [N_BITS-1:0] r_data_a;
    logic [N_BITS-1:0] r_data_b;
    logic [N_OPS-1:0]  r_op;
    logic [N_BYTE-1:0] r_tx_data;
    logic              r_tx_start;
    logic              r_rx_dropped;

    logic w_lat_clr;
    logic w_lat_en;
    logic w_lat_tc;
    logic w_timeout;

    // Upper receive bits beyond the field widths are intentionally ignored.
    logic w_unused_rx_bits;
    assign w_unused_rx_bits = ^rx_data;

    // The latency count starts from zero on the opcode capture edge.
    assign w_lat_clr = (r_state == GET_OP) && rx_valid;
    assign w_lat_en  = (r_state == EXEC);

    alu_if_counter #(
        .WIDTH    (c_LAT_W),
        .TERMINAL (ALU_LAT - 1)
    ) u_lat_cnt (
        .clk   (clock),
        .rst   (reset),
        .i_clr (w_lat_clr),
        .i_en  (w_lat_en),
        .o_tc  (w_lat_tc)
    );

`ifdef ALU_IF_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic w_to_wait;
    logic w_to_clr;
    logic w_to_tc;

    // Timeout runs only while waiting for B or the opcode; any byte restarts it.
    assign w_to_wait = (r_state == GET_B) || (r_state == GET_OP);
    assign w_to_clr  = !w_to_wait || rx_valid;

    alu_if_counter #(
        .WIDTH    (c_TO_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_to_cnt (
        .clk   (clock),
        .rst   (reset),
        .i_clr (w_to_clr),
        .i_en  (w_to_wait),
        .o_tc  (w_to_tc)
    );

    assign w_timeout = w_to_wait && w_to_tc && !rx_valid;
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    // Frame sequencer with registered ALU operands and transmitter controls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= GET_A;
            r_data_a     <= '0;
            r_data_b     <= '0;
            r_op         <= '0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_rx_dropped <= 1'b0;
        end else begin
            r_tx_start   <= 1'b0;
            r_rx_dropped <= 1'b0;
            case (r_state)
                GET_A: begin
                    if (rx_valid) begin
                        r_data_a <= rx_data[N_BITS-1:0];
                        r_state  <= GET_B;
                    end
                end
                GET_B: begin
                    if (rx_valid) begin
                        r_data_b <= rx_data[N_BITS-1:0];
                        r_state  <= GET_OP;
                    end else if (w_timeout) begin
                        r_state  <= GET_A;
                    end
                end
                GET_OP: begin
                    if (rx_valid) begin
                        r_op    <= rx_data[N_OPS-1:0];
                        r_state <= EXEC;
                    end else if (w_timeout) begin
                        r_state <= GET_A;
                    end
                end
                EXEC: begin
                    r_rx_dropped <= rx_valid;
                    if (w_lat_tc) begin
                        r_tx_data <= N_BYTE'(alu_result);
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    r_rx_dropped <= rx_valid;
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_state    <= GET_A;
                    end
                end
                default: begin
                    r_state <= GET_A;
                end
            endcase
        end
    end

    assign Data_A     = r_data_a;
    assign Data_B     = r_data_b;
    assign Op         = r_op;
    assign tx_data    = r_tx_data;
    assign tx_start   = r_tx_start;
    assign rx_dropped = r_rx_dropped;

endmodule
`default_nettype wire

// File: tb/tb_alu_frame_interface.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_frame_interface
//  Description : Self-checking bench for alu_frame_interface with a
//                registered behavioural ALU and a frame-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_frame_interface;
    import alu_if_pkg::*;

    localparam int N_BITS  = 6;
    localparam int N_OPS   = 6;
    localparam int N_BYTE  = 8;
    localparam int ALU_LAT = 2;
    localparam int TO_CYC  = 100;

    logic              clock = 1'b0;
    logic              reset;
    logic [N_BYTE-1:0] rx_data;
    logic              rx_valid;
    logic [N_BITS-1:0] Data_A;
    logic [N_BITS-1:0] Data_B;
    logic [N_OPS-1:0]  Op;
    logic [N_BITS-1:0] alu_result;
    logic [N_BYTE-1:0] tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              rx_dropped;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int drop_cnt = 0;

    alu_frame_interface #(
        .N_BITS         (N_BITS),
        .N_OPS          (N_OPS),
        .N_BYTE         (N_BYTE),
        .ALU_LAT        (ALU_LAT),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .Data_A     (Data_A),
        .Data_B     (Data_B),
        .Op         (Op),
        .alu_result (alu_result),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .rx_dropped (rx_dropped)
    );

    always #5 clock = ~clock;

    // ALU arithmetic as the ALU defines it; unknown opcodes give zero.
    function automatic logic [5:0] alu_ref(input logic [5:0] a, input logic [5:0] b,
                                           input logic [5:0] op);
        logic signed [5:0] sa;
        sa = a;
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            XOR:     return a ^ b;
            SRA:     return sa >>> b;
            SRL:     return a >> b;
            NOR:     return ~(a | b);
            default: return 6'd0;
        endcase
    endfunction

    // Stand-in ALU with a registered result, as in the real top level.
    always @(posedge clock or posedge reset) begin
        if (reset) alu_result <= '0;
        else       alu_result <= alu_ref(Data_A, Data_B, Op);
    end

    // Pulse counters sampled away from the active edge.
    always @(negedge clock) begin
        if (tx_start)   start_cnt++;
        if (rx_dropped) drop_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic wait_tx(output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (tx_start) break;
        end
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input string tag);
        int cyc;
        logic [7:0] exp;
        exp = {2'b00, alu_ref(a[5:0], b[5:0], op[5:0])};
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check({tag, ".A"}, 32'(Data_A), 32'(a[5:0]));
        check({tag, ".B"}, 32'(Data_B), 32'(b[5:0]));
        check({tag, ".Op"}, 32'(Op), 32'(op[5:0]));
        wait_tx(cyc);
        check({tag, ".lat"}, 32'(cyc), 32'(ALU_LAT + 1));
        check({tag, ".tx"}, 32'(tx_data), 32'(exp));
        @(negedge clock);
        check({tag, ".pulse"}, 32'(tx_start), 32'd0);
    endtask

    initial begin
        int cyc;
        int s0;
        int d0;
        int bad;
        logic [7:0] ra, rb, rop;
        logic [5:0] ops [9];
        ops = '{ADD, SUB, AND, OR, XOR, SRA, SRL, NOR, 6'h3A};

        reset    = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst.A", 32'(Data_A), 0);
        check("rst.B", 32'(Data_B), 0);
        check("rst.Op", 32'(Op), 0);
        check("rst.tx", 32'(tx_data), 0);
        check("rst.start", 32'(tx_start), 0);
        check("rst.drop", 32'(rx_dropped), 0);

        // Directed frames: add, subtract wrap, overflow wrap.
        run_frame(8'h05, 8'h03, 8'h20, "add");
        run_frame(8'h03, 8'h05, 8'h22, "sub");
        run_frame(8'h3F, 8'h01, 8'h20, "ovf");

        // Transmitter busy for 50 cycles, then a byte on the exit cycle.
        send_byte(8'h0C);
        send_byte(8'h0A);
        tx_busy = 1'b1;
        send_byte({2'b00, XOR});
        s0  = start_cnt;
        d0  = drop_cnt;
        bad = 0;
        repeat (2) @(negedge clock);
        repeat (50) begin
            @(negedge clock);
            if (tx_data !== 8'h06) bad++;
        end
        check("busy.nostart", 32'(start_cnt), 32'(s0));
        check("busy.stable", 32'(bad), 0);
        tx_busy  = 1'b0;
        rx_data  = 8'h11;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
        check("busy.start", 32'(tx_start), 1);
        check("busy.exitdrop", 32'(rx_dropped), 1);
        @(negedge clock);
        check("busy.once", 32'(start_cnt), 32'(s0 + 1));
        check("busy.dropcnt", 32'(drop_cnt), 32'(d0 + 1));
        run_frame(8'h09, 8'h04, {2'b00, SUB}, "after_busy");

        // Byte arriving during EXEC is dropped without disturbing the result.
        send_byte(8'h15);
        send_byte(8'h0B);
        send_byte({2'b00, AND});
        d0       = drop_cnt;
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
        check("exec.drop", 32'(rx_dropped), 1);
        wait_tx(cyc);
        check("exec.lat", 32'(cyc), 32'(ALU_LAT));
        check("exec.tx", 32'(tx_data), 32'h01);
        @(negedge clock);
        check("exec.dropcnt", 32'(drop_cnt), 32'(d0 + 1));
        run_frame(8'h22, 8'h11, {2'b00, OR}, "after_drop");

        // Asynchronous reset mid-frame.
        send_byte(8'h09);
        send_byte(8'h0A);
        check("pre_rst.A", 32'(Data_A), 32'h09);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst.A", 32'(Data_A), 0);
        check("arst.B", 32'(Data_B), 0);
        check("arst.Op", 32'(Op), 0);
        check("arst.tx", 32'(tx_data), 0);
        @(negedge clock);
        reset = 1'b0;
        run_frame(8'h07, 8'h01, 8'h25, "post_rst");

        // Inter-byte gap of TO_CYC cycles after operand A.
        send_byte(8'h01);
        repeat (TO_CYC) @(negedge clock);
        send_byte(8'h2A);
`ifdef ALU_IF_TIMEOUT_EN
        check("to.A", 32'(Data_A), 32'h2A);
        send_byte(8'h01);
`else
        check("to.A", 32'(Data_A), 32'h01);
        check("to.B", 32'(Data_B), 32'h2A);
`endif
        send_byte({2'b00, ADD});
        wait_tx(cyc);
        check("to.lat", 32'(cyc), 32'(ALU_LAT + 1));
        check("to.tx", 32'(tx_data), 32'h2B);

        // Randomized frames, including ignored upper bits and unknown opcodes.
        for (int i = 0; i < 12; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = {2'($urandom), ops[$urandom_range(0, 8)]};
            repeat ($urandom_range(0, 3)) @(negedge clock);
            run_frame(ra, rb, rop, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
